// File: rtl/mem_rd_arbiter.sv
// Single-outstanding AXI read arbiter between the fetch refill path and the data path.
// Fetch transactions cancelled by a flush still complete on AXI but deliver nothing upstream.
module mem_rd_arbiter #(
  parameter logic [3:0] ID_I = 4'd0,
  parameter logic [3:0] ID_D = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic [3:0]  i_len,
  input  logic        i_cancel,
  output logic        i_ack,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  output logic        i_rlast,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_len,
  input  logic [2:0]  d_size,
  output logic        d_ack,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_rlast,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  ar_id_reg;
  logic [31:0] ar_addr_reg;
  logic [3:0]  ar_len_reg;
  logic [2:0]  ar_size_reg;
  logic        owner_d_reg;
  logic        drop_reg;
  logic        last_d_reg;
  logic        beat_valid_reg;
  logic [31:0] beat_data_reg;
  logic        beat_last_reg;

  logic grant_d;
  logic req_any;
  logic ar_hs;
  logic r_hs;
  logic unused_axi;

  // Data wins a tie unless it won the previous grant, so fetch cannot starve.
  assign grant_d    = d_req & (~i_req | ~last_d_reg);
  assign req_any    = i_req | d_req;
  assign ar_hs      = (state_reg == ADDR) & arready;
  assign r_hs       = (state_reg == DATA) & rvalid;
  assign unused_axi = ^{rid, rresp};

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_any) state_next = ADDR;
      ADDR:    if (arready) state_next = DATA;
      DATA:    if (rvalid && rlast) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    arvalid  = (state_reg == ADDR);
    rready   = (state_reg == DATA);
    i_ack    = ar_hs & ~owner_d_reg & ~drop_reg & ~i_cancel;
    d_ack    = ar_hs & owner_d_reg;
    i_rvalid = beat_valid_reg & ~owner_d_reg & ~drop_reg;
    d_rvalid = beat_valid_reg & owner_d_reg;
    i_rdata  = i_rvalid ? beat_data_reg : 32'd0;
    d_rdata  = d_rvalid ? beat_data_reg : 32'd0;
    i_rlast  = i_rvalid & beat_last_reg;
    d_rlast  = d_rvalid & beat_last_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ar_id_reg      <= 4'd0;
      ar_addr_reg    <= 32'd0;
      ar_len_reg     <= 4'd0;
      ar_size_reg    <= 3'd0;
      owner_d_reg    <= 1'b0;
      drop_reg       <= 1'b0;
      last_d_reg     <= 1'b0;
      beat_valid_reg <= 1'b0;
      beat_data_reg  <= 32'd0;
      beat_last_reg  <= 1'b0;
    end else begin
      if (state_reg == IDLE && req_any) begin
        ar_id_reg   <= grant_d ? ID_D : ID_I;
        ar_addr_reg <= grant_d ? d_addr : i_addr;
        ar_len_reg  <= grant_d ? d_len : i_len;
        ar_size_reg <= grant_d ? d_size : 3'b010;
        owner_d_reg <= grant_d;
        drop_reg    <= 1'b0;
        last_d_reg  <= grant_d;
      end else if (state_reg != IDLE && i_cancel && !owner_d_reg) begin
        drop_reg <= 1'b1;
      end
      beat_valid_reg <= r_hs;
      beat_last_reg  <= r_hs & rlast;
      if (r_hs) beat_data_reg <= rdata;
    end
  end

  assign arid    = ar_id_reg;
  assign araddr  = ar_addr_reg;
  assign arlen   = {4'd0, ar_len_reg};
  assign arsize  = ar_size_reg;
  assign arburst = 2'b01;

endmodule
